// File: rtl/guess_sequencer.sv
// Brute-force candidate generator: odometer over a 62-symbol alphabet from cfg_min_len to cfg_max_len.
// Define GUESS_COUNT_EN to build the saturating accepted-guess counter; otherwise guess_count is tied to 0.
module guess_sequencer #(
    parameter int MAX_LEN      = 16,
    parameter int CHARSET_SIZE = 62
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [3:0]           cfg_min_len,
    input  logic [3:0]           cfg_max_len,
    input  logic                 guess_ready,
    output logic                 guess_valid,
    output logic [8*MAX_LEN-1:0] guess,
    output logic [3:0]           length,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [47:0]          guess_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [MAX_LEN-1:0][5:0] r_idx;
    logic [MAX_LEN-1:0][5:0] w_idx_inc;
    logic [3:0]              r_len;
    logic [3:0]              r_max;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cfg_err;
    logic                    w_accept;
    logic                    w_wrap;
    logic                    w_cfg_bad;
    logic                    w_start_ok;

    function automatic logic [7:0] f_char(input logic [5:0] idx);
        if (idx < 6'd26)
            return 8'h61 + {2'b00, idx};
        else if (idx < 6'd52)
            return 8'h41 + {2'b00, idx - 6'd26};
        else
            return 8'h30 + {2'b00, idx - 6'd52};
    endfunction

    assign w_cfg_bad  = (cfg_min_len == 4'd0) || (cfg_min_len > cfg_max_len) ||
                        (int'(cfg_max_len) > MAX_LEN);
    assign w_start_ok = start && (r_state != S_RUN);
    assign w_accept   = (r_state == S_RUN) && r_valid && guess_ready;

    // Ripple the +1 from char 0 upward; w_wrap flags carry out of the top active position.
    always_comb begin
        logic w_carry;
        w_carry   = 1'b1;
        w_wrap    = 1'b0;
        w_idx_inc = r_idx;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(r_len)) && w_carry) begin
                if (r_idx[i] == 6'(CHARSET_SIZE - 1)) begin
                    w_idx_inc[i] = 6'd0;
                    if (i + 1 == int'(r_len))
                        w_wrap = 1'b1;
                end else begin
                    w_idx_inc[i] = r_idx[i] + 6'd1;
                    w_carry      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        guess = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(r_len))
                guess[8*i +: 8] = f_char(r_idx[i]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len     <= 4'd0;
            r_max     <= 4'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len     <= 4'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (w_cfg_bad) begin
                            r_state   <= S_DONE;
                            r_valid   <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            r_idx     <= '0;
                            r_len     <= cfg_min_len;
                            r_max     <= cfg_max_len;
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                            r_cfg_err <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (!w_wrap) begin
                            r_idx <= w_idx_inc;
                        end else if (r_len < r_max) begin
                            r_len <= r_len + 4'd1;
                            r_idx <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign guess_valid = r_valid;
    assign length      = r_len;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;

`ifdef GUESS_COUNT_EN
    logic [47:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_count <= '0;
        else if (abort)
            r_count <= r_count;
        else if (w_start_ok)
            r_count <= '0;
        else if (w_accept && (r_count != '1))
            r_count <= r_count + 48'd1;
    end

    assign guess_count = r_count;
`else
    assign guess_count = '0;
`endif

endmodule

// File: tb/tb_guess_sequencer.sv
// Bench for guess_sequencer: config table, directed corner sequences, and randomized runs against an index-arithmetic model.
module tb_guess_sequencer;

`ifdef GUESS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic n_rst;

    logic         a_start, a_abort, a_ready;
    logic [3:0]   a_min, a_max;
    logic         a_valid, a_busy, a_done, a_err;
    logic [127:0] a_guess;
    logic [3:0]   a_len;
    logic [47:0]  a_cnt;

    logic         b_start, b_abort, b_ready;
    logic [3:0]   b_min, b_max;
    logic         b_valid, b_busy, b_done, b_err;
    logic [31:0]  b_guess;
    logic [3:0]   b_len;
    logic [47:0]  b_cnt;

    guess_sequencer u_a (
        .clk(clk), .n_rst(n_rst), .start(a_start), .abort(a_abort),
        .cfg_min_len(a_min), .cfg_max_len(a_max), .guess_ready(a_ready),
        .guess_valid(a_valid), .guess(a_guess), .length(a_len), .busy(a_busy),
        .done(a_done), .cfg_err(a_err), .guess_count(a_cnt)
    );

    guess_sequencer #(.MAX_LEN(4), .CHARSET_SIZE(2)) u_b (
        .clk(clk), .n_rst(n_rst), .start(b_start), .abort(b_abort),
        .cfg_min_len(b_min), .cfg_max_len(b_max), .guess_ready(b_ready),
        .guess_valid(b_valid), .guess(b_guess), .length(b_len), .busy(b_busy),
        .done(b_done), .cfg_err(b_err), .guess_count(b_cnt)
    );

    int total = 0;
    int bad   = 0;
    string alphabet = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_guess(input int len, input longint k, input int cs);
        logic [127:0] g;
        longint r;
        g = '0;
        r = k;
        for (int i = 0; i < len; i++) begin
            g[8*i +: 8] = alphabet[int'(r % cs)];
            r = r / cs;
        end
        return g;
    endfunction

    function automatic longint ipow(input int b, input int e);
        longint p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * b;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_abort_pulse();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
    endtask

    typedef struct {
        logic [3:0] mn;
        logic [3:0] mx;
        logic       err;
    } vec_t;

    vec_t tbl[6];

    logic [31:0] seq31[6];

    initial begin
        bit     m_run, m_done, m_err, ab, rd;
        int     mn, mx, len;
        longint k, cnt;

        tbl[0] = '{4'd3, 4'd2, 1'b1};
        tbl[1] = '{4'd0, 4'd1, 1'b1};
        tbl[2] = '{4'd1, 4'd5, 1'b1};
        tbl[3] = '{4'd1, 4'd4, 1'b0};
        tbl[4] = '{4'd4, 4'd4, 1'b0};
        tbl[5] = '{4'd2, 4'd3, 1'b0};
        seq31[0] = 32'h61;   seq31[1] = 32'h62;   seq31[2] = 32'h6161;
        seq31[3] = 32'h6162; seq31[4] = 32'h6261; seq31[5] = 32'h6262;

        n_rst = 1'b0;
        a_start = 0; a_abort = 0; a_ready = 0; a_min = 0; a_max = 0;
        b_start = 0; b_abort = 0; b_ready = 0; b_min = 0; b_max = 0;
        tick(); tick();
        chk("rst_valid", a_valid, 0); chk("rst_guess", a_guess, 0);
        chk("rst_len", a_len, 0);     chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);   chk("rst_err", a_err, 0);
        chk("rst_cnt", a_cnt, 0);
        n_rst = 1'b1;
        tick();

        // Configuration table on the small instance (MAX_LEN=4, two symbols)
        for (int i = 0; i < 6; i++) begin
            b_min = tbl[i].mn; b_max = tbl[i].mx; b_ready = 1'b0;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            b_min = 4'd0; b_max = 4'd0;
            chk($sformatf("tbl%0d_done", i), b_done, tbl[i].err);
            chk($sformatf("tbl%0d_err", i), b_err, tbl[i].err);
            chk($sformatf("tbl%0d_valid", i), b_valid, !tbl[i].err);
            chk($sformatf("tbl%0d_busy", i), b_busy, !tbl[i].err);
            if (!tbl[i].err) begin
                chk($sformatf("tbl%0d_len", i), b_len, tbl[i].mn);
                chk($sformatf("tbl%0d_guess", i), b_guess, model_guess(int'(tbl[i].mn), 0, 2));
                chk($sformatf("tbl%0d_cnt", i), b_cnt, 0);
            end
            tick();
            chk($sformatf("tbl%0d_hold_done", i), b_done, tbl[i].err);
            chk($sformatf("tbl%0d_hold_err", i), b_err, tbl[i].err);
            chk($sformatf("tbl%0d_hold_valid", i), b_valid, !tbl[i].err);
            b_abort = 1'b1;
            tick();
            b_abort = 1'b0;
            chk($sformatf("tbl%0d_abort_valid", i), b_valid, 0);
            chk($sformatf("tbl%0d_abort_busy", i), b_busy, 0);
            chk($sformatf("tbl%0d_abort_done", i), b_done, 0);
            chk($sformatf("tbl%0d_abort_err", i), b_err, 0);
        end

        // Two-symbol exhaustion over lengths 1..2
        b_min = 4'd1; b_max = 4'd2; b_ready = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("cs2_valid%0d", j), b_valid, 1);
            chk($sformatf("cs2_guess%0d", j), b_guess, seq31[j]);
            tick();
        end
        chk("cs2_done", b_done, 1);
        chk("cs2_valid_end", b_valid, 0);
        chk("cs2_cnt", b_cnt, CNT_EN ? 48'd6 : 48'd0);
        b_ready = 1'b0;
        b_abort = 1'b1; tick(); b_abort = 1'b0;

        // Full single-character sweep on default instance
        a_min = 4'd1; a_max = 4'd1; a_ready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int j = 0; j < 62; j++) begin
            if (a_valid !== 1'b1 || a_guess !== model_guess(1, j, 62))
                chk($sformatf("sweep%0d", j), a_guess, model_guess(1, j, 62));
            if (j == 61) chk("sweep_last_byte", a_guess[7:0], 8'h39);
            tick();
        end
        chk("sweep_done", a_done, 1);
        chk("sweep_valid_end", a_valid, 0);
        chk("sweep_cnt", a_cnt, CNT_EN ? 48'd62 : 48'd0);
        a_abort_pulse();

        // Back-pressure: three stalled cycles then resume
        a_min = 4'd1; a_max = 4'd2; a_ready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick(); tick();
        a_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("stall%0d_guess", j), a_guess, 128'h63);
            chk($sformatf("stall%0d_valid", j), a_valid, 1);
            tick();
        end
        a_ready = 1'b1;
        chk("stall_release", a_guess, 128'h63);
        tick();
        chk("stall_successor", a_guess, 128'h64);
        chk("stall_len", a_len, 1);

        // Abort beats start and ready in the same cycle
        a_abort = 1'b1; a_start = 1'b1;
        tick();
        a_abort = 1'b0; a_start = 1'b0;
        chk("abort_valid", a_valid, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        tick();
        chk("abort_idle_valid", a_valid, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("restart_guess", a_guess, 128'h61);
        chk("restart_len", a_len, 1);

        // Asynchronous reset between clock edges mid-run
        tick(); tick();
        #2 n_rst = 1'b0;
        #1;
        chk("async_valid", a_valid, 0); chk("async_guess", a_guess, 0);
        chk("async_len", a_len, 0);     chk("async_busy", a_busy, 0);
        chk("async_done", a_done, 0);   chk("async_err", a_err, 0);
        chk("async_cnt", a_cnt, 0);
        tick();
        #2 n_rst = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_valid", a_valid, 0);
        chk("post_rst_busy", a_busy, 0);
        chk("post_rst_done", a_done, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("post_rst_start", a_guess, 128'h61);
        a_abort_pulse();

        // Randomized runs with random ready, ignored mid-run start/config, occasional abort
        for (int run = 0; run < 10; run++) begin
            mn = int'($urandom_range(1, 2));
            mx = int'($urandom_range(mn, 2));
            if ($urandom_range(0, 4) == 0) begin
                mn = 2; mx = 1;
            end
            if (run < 3) mx = 1;
            a_min = 4'(mn); a_max = 4'(mx); a_start = 1'b1;
            if (mn == 0 || mn > mx || mx > 16) begin
                m_run = 0; m_done = 1; m_err = 1;
            end else begin
                m_run = 1; m_done = 0; m_err = 0;
            end
            len = mn; k = 0; cnt = 0;
            tick();
            a_start = 1'b0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                chk("rnd_valid", a_valid, m_run);
                chk("rnd_busy", a_busy, m_run);
                chk("rnd_done", a_done, m_done);
                chk("rnd_err", a_err, m_err);
                chk("rnd_cnt", a_cnt, CNT_EN ? 48'(cnt) : 48'd0);
                if (m_run) begin
                    chk("rnd_guess", a_guess, model_guess(len, k, 62));
                    chk("rnd_len", a_len, 4'(len));
                end
                ab = ($urandom_range(0, 199) == 0);
                rd = ($urandom_range(0, 3) != 0);
                a_abort = ab;
                a_ready = rd;
                a_start = m_run && ($urandom_range(0, 29) == 0);
                a_min   = 4'($urandom);
                a_max   = 4'($urandom);
                if (ab) begin
                    m_run = 0; m_done = 0; m_err = 0;
                end else if (m_run && rd) begin
                    cnt++;
                    k++;
                    if (k == ipow(62, len)) begin
                        if (len < mx) begin
                            len++;
                            k = 0;
                        end else begin
                            m_run = 0; m_done = 1;
                        end
                    end
                end
                tick();
                a_start = 1'b0;
            end
            a_abort = 1'b0;
            a_ready = 1'b0;
            a_abort_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
